// File: rtl/proc_pkg.sv
// Shared definitions for the processor-core control sequencer:
// opcode classes, sequencer states and the opcode field width.
package proc_pkg;

  localparam int OPCODE_WIDTH = 8;
  localparam int CLASS_WIDTH  = 4;

  localparam logic [CLASS_WIDTH-1:0] CLS_DONE      = 4'd0;
  localparam logic [CLASS_WIDTH-1:0] CLS_PULSE     = 4'd1;
  localparam logic [CLASS_WIDTH-1:0] CLS_REG_ALU   = 4'd2;
  localparam logic [CLASS_WIDTH-1:0] CLS_JUMP      = 4'd3;
  localparam logic [CLASS_WIDTH-1:0] CLS_JUMP_COND = 4'd4;
  localparam logic [CLASS_WIDTH-1:0] CLS_INC_QCLK  = 4'd5;
  localparam logic [CLASS_WIDTH-1:0] CLS_SYNC      = 4'd6;
  localparam logic [CLASS_WIDTH-1:0] CLS_FPROC     = 4'd7;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_FETCH      = 4'd1,
    ST_DECODE     = 4'd2,
    ST_ALU_WB     = 4'd3,
    ST_PULSE_WAIT = 4'd4,
    ST_SYNC_WAIT  = 4'd5,
    ST_FPROC_WAIT = 4'd6,
    ST_HALT_DONE  = 4'd7,
    ST_HALT_ERR   = 4'd8
  } state_e;

  function automatic logic [CLASS_WIDTH-1:0] op_class(input logic [OPCODE_WIDTH-1:0] op);
    return op[OPCODE_WIDTH-1 -: CLASS_WIDTH];
  endfunction

endpackage

// File: rtl/proc_ctrl.sv
// Fetch/decode/execute sequencer of the processor core: drives the pointer,
// ALU selects, register write, qclk load, pulse strobe and wait handshakes.
module proc_ctrl
  import proc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    alu_cond,
  input  logic [DATA_WIDTH-1:0]   qclk_val,
  input  logic [DATA_WIDTH-1:0]   pulse_time,
  input  logic                    sync_ready,
  input  logic                    fproc_ready,
  output logic                    inst_ptr_reset,
  output logic                    inst_ptr_enable,
  output logic                    inst_ptr_load_en,
  output logic                    qclk_reset,
  output logic                    qclk_load_en,
  output logic [2:0]              alu_opcode,
  output logic                    alu_in0_sel,
  output logic                    reg_write_en,
  output logic                    reg_write_sel,
  output logic                    cstrobe,
  output logic                    sync_barrier_en_out,
  output logic                    fproc_en_out,
  output logic                    done,
  output logic                    err,
  output logic                    pulse_late
);

  state_e                 state_q, state_d;
  logic                   pulse_late_q, pulse_late_d;
  logic [CLASS_WIDTH-1:0] cls_s;
  logic [DATA_WIDTH-1:0]  diff_s;
  logic                   pulse_due_s, pulse_after_s;
  logic                   ptr_reset_s, ptr_en_s, ptr_load_s;
  logic                   qclk_reset_s, qclk_load_s;
  logic                   reg_we_s, reg_sel_s, cstrobe_s;
  logic                   sync_en_s, fproc_en_s;

  // Modular difference read as signed keeps the pulse comparison correct across qclk wrap.
  assign cls_s         = op_class(opcode);
  assign diff_s        = qclk_val - pulse_time;
  assign pulse_due_s   = ~diff_s[DATA_WIDTH-1];
  assign pulse_after_s = pulse_due_s & (|diff_s);

  // Next-state and Mealy strobe decode.
  always_comb begin
    state_d      = state_q;
    pulse_late_d = pulse_late_q;
    ptr_reset_s  = 1'b0;
    ptr_en_s     = 1'b0;
    ptr_load_s   = 1'b0;
    qclk_reset_s = 1'b0;
    qclk_load_s  = 1'b0;
    reg_we_s     = 1'b0;
    reg_sel_s    = 1'b0;
    cstrobe_s    = 1'b0;
    sync_en_s    = 1'b0;
    fproc_en_s   = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT_DONE, ST_HALT_ERR: begin
        if (start) begin
          ptr_reset_s  = 1'b1;
          qclk_reset_s = 1'b1;
          pulse_late_d = 1'b0;
          state_d      = ST_FETCH;
        end else begin
          state_d = state_q;
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        case (cls_s)
          CLS_DONE: state_d = ST_HALT_DONE;
          CLS_PULSE: begin
            if (pulse_due_s) begin
              cstrobe_s    = 1'b1;
              ptr_en_s     = 1'b1;
              pulse_late_d = pulse_late_q | pulse_after_s;
              state_d      = ST_FETCH;
            end else begin
              state_d = ST_PULSE_WAIT;
            end
          end
          CLS_REG_ALU, CLS_JUMP_COND, CLS_INC_QCLK: state_d = ST_ALU_WB;
          CLS_JUMP: begin
            ptr_load_s = 1'b1;
            state_d    = ST_FETCH;
          end
          CLS_SYNC:  state_d = ST_SYNC_WAIT;
          CLS_FPROC: state_d = ST_FPROC_WAIT;
          default:   state_d = ST_HALT_ERR;
        endcase
      end
      ST_ALU_WB: begin
        state_d = ST_FETCH;
        case (cls_s)
          CLS_REG_ALU: begin
            reg_we_s = 1'b1;
            ptr_en_s = 1'b1;
          end
          CLS_INC_QCLK: begin
            qclk_load_s = 1'b1;
            ptr_en_s    = 1'b1;
          end
          CLS_JUMP_COND: begin
            if (alu_cond) begin
              ptr_load_s = 1'b1;
            end else begin
              ptr_en_s = 1'b1;
            end
          end
          default: state_d = ST_HALT_ERR;
        endcase
      end
      ST_PULSE_WAIT: begin
        if (qclk_val == pulse_time) begin
          cstrobe_s = 1'b1;
          ptr_en_s  = 1'b1;
          state_d   = ST_FETCH;
        end else begin
          state_d = ST_PULSE_WAIT;
        end
      end
      ST_SYNC_WAIT: begin
        sync_en_s = 1'b1;
        if (sync_ready) begin
          ptr_en_s = 1'b1;
          state_d  = ST_FETCH;
        end else begin
          state_d = ST_SYNC_WAIT;
        end
      end
      ST_FPROC_WAIT: begin
        fproc_en_s = 1'b1;
        if (fproc_ready) begin
          reg_we_s  = 1'b1;
          reg_sel_s = 1'b1;
          ptr_en_s  = 1'b1;
          state_d   = ST_FETCH;
        end else begin
          state_d = ST_FPROC_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and sticky late-pulse flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      pulse_late_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pulse_late_q <= pulse_late_d;
    end
  end

  // Gating with reset makes every output drop the instant reset asserts.
  assign inst_ptr_reset      = reset & ptr_reset_s;
  assign inst_ptr_enable     = reset & ptr_en_s;
  assign inst_ptr_load_en    = reset & ptr_load_s;
  assign qclk_reset          = reset & qclk_reset_s;
  assign qclk_load_en        = reset & qclk_load_s;
  assign reg_write_en        = reset & reg_we_s;
  assign reg_write_sel       = reset & reg_sel_s;
  assign cstrobe             = reset & cstrobe_s;
  assign sync_barrier_en_out = reset & sync_en_s;
  assign fproc_en_out        = reset & fproc_en_s;
  assign done                = reset & (state_q == ST_HALT_DONE);
  assign err                 = reset & (state_q == ST_HALT_ERR);
  assign pulse_late          = reset & pulse_late_q;
  assign alu_opcode          = reset ? opcode[2:0] : 3'b000;
  assign alu_in0_sel         = reset & opcode[3];

endmodule

// File: doc/proc_ctrl.md
# proc_ctrl

Control sequencer for the distributed processor core. Decodes the opcode field of the command word presented by the command buffer and drives the core's other blocks through fetch/decode/execute. Those blocks are the instruction pointer, ALU operand selects, register-file write, qclk load, and the cstrobe pulse output. It also owns the sync-barrier and fproc request/ready handshakes. It sits inside `proc`, between `cmd_mem`/`instr_ptr` and the datapath.

## Interface
- DATA_WIDTH, 32, qclk and pulse-time width
- OPCODE_WIDTH, 8, opcode field width (top bits of command word)

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin execution at address 0 (sampled in IDLE/DONE/ERR)
- opcode  in  8  cmd_buf_out[CMD_WIDTH-1 -: 8]; [7:4] class, [3] ALU in0 select, [2:0] ALU op
- alu_cond  in  1  alu_out[0], valid one cycle after operands are selected
- qclk_val  in  DATA_WIDTH  current qclk
- pulse_time  in  DATA_WIDTH  pulse command time field
- sync_ready  in  1  barrier released
- fproc_ready  in  1  fproc result valid
- inst_ptr_reset  out  1  clear instruction pointer
- inst_ptr_enable  out  1  pointer +1
- inst_ptr_load_en  out  1  pointer <= jump target
- qclk_reset  out  1  clear qclk
- qclk_load_en  out  1  qclk <= alu_out
- alu_opcode  out  3  opcode[2:0]
- alu_in0_sel  out  1  opcode[3]
- reg_write_en  out  1  register-file write strobe
- reg_write_sel  out  1  0 = alu_out, 1 = fproc data
- cstrobe  out  1  one-cycle pulse-command strobe
- sync_barrier_en_out  out  1  barrier request, level
- fproc_en_out  out  1  fproc request, level
- done  out  1  halted on DONE
- err  out  1  halted on illegal class
- pulse_late  out  1  sticky; a pulse issued after its time

## Operation
- Classes (opcode[7:4]):
  - 0 DONE
  - 1 PULSE
  - 2 REG_ALU
  - 3 JUMP
  - 4 JUMP_COND
  - 5 INC_QCLK
  - 6 SYNC
  - 7 FPROC
  - 8–15 illegal.
- States: IDLE, FETCH, DECODE, ALU_WB, PULSE_WAIT, SYNC_WAIT, FPROC_WAIT, HALT_DONE, HALT_ERR.
- IDLE/HALT_*:
  - On `start`, pulse inst_ptr_reset, qclk_reset, and clear pulse_late.
  - Next state FETCH.
- FETCH: one cycle for the synchronous cmd_mem read; then DECODE.
- DECODE, by class:
  - DONE → HALT_DONE.
  - PULSE: evaluate d = qclk_val − pulse_time as a signed DATA_WIDTH value (wrap-safe).
    - d ≥ 0: assert cstrobe and inst_ptr_enable in this cycle, → FETCH.
    - d > 0: additionally set pulse_late.
    - d < 0: → PULSE_WAIT.
  - REG_ALU / JUMP_COND / INC_QCLK: → ALU_WB.
  - JUMP: assert inst_ptr_load_en, → FETCH.
  - SYNC: → SYNC_WAIT.
  - FPROC: → FPROC_WAIT.
  - Illegal: → HALT_ERR.
- ALU_WB, by class:
  - REG_ALU: reg_write_en=1 with reg_write_sel=0, plus inst_ptr_enable.
  - INC_QCLK: qclk_load_en=1, plus inst_ptr_enable.
  - JUMP_COND: if alu_cond, inst_ptr_load_en; else inst_ptr_enable.
  - All three → FETCH.
- PULSE_WAIT: on the first cycle with qclk_val == pulse_time, assert cstrobe and inst_ptr_enable, → FETCH.
- SYNC_WAIT:
  - sync_barrier_en_out is high for every cycle in this state.
  - On sync_ready, assert inst_ptr_enable, → FETCH.
- FPROC_WAIT:
  - fproc_en_out is high in this state.
  - On fproc_ready, assert reg_write_en with reg_write_sel=1, plus inst_ptr_enable, → FETCH.
- At most one of inst_ptr_enable / inst_ptr_load_en / inst_ptr_reset is high in any cycle.
- alu_opcode and alu_in0_sel follow opcode combinationally.

## Timing
- Reset: all outputs 0, state IDLE, pulse_late cleared.
- Reset mid-handshake: request outputs drop immediately (asynchronous); no strobe is emitted.
- Cycles per instruction, including FETCH:
  - JUMP, and PULSE with d ≥ 0: 2 cycles.
  - REG_ALU, JUMP_COND, INC_QCLK: 3 cycles.
  - Waits: 2 + wait cycles.
- cstrobe is registered in no way: it is a Mealy output in DECODE/PULSE_WAIT, coincident with the cycle where qclk_val matches.
- ready inputs are ignored outside their wait state.
- ready asserted in the same cycle the state is entered is not seen; it is first sampled on the next edge.
- `start` while running is ignored.

## Structure
- Shared package `proc_pkg`:
  - opcode class localparams
  - state enum
  - OPCODE_WIDTH
- Single module; no sub-module warranted.

## Test plan
- Program JUMP(5) at address 0 → inst_ptr_load_en high in cycle 2 after start; no inst_ptr_enable.
- PULSE with pulse_time=100, qclk reaches 100 at cycle 40 → exactly one cstrobe, when qclk_val==100; pulse_late stays 0.
- PULSE with pulse_time=10, qclk=50 at decode → cstrobe in the DECODE cycle; pulse_late=1 until the next start.
- PULSE with qclk=0xFFFFFFF0 and pulse_time=0x00000005 → waits through the wrap and fires at 5.
- SYNC with sync_ready after 7 cycles → sync_barrier_en_out high 7 cycles, then drops with inst_ptr_enable; reset asserted mid-wait → outputs 0 asynchronously.
- JUMP_COND with alu_cond=0, then =1; opcode class 0xA → pointer +1, then load; then err=1 with all strobes idle.
